// File: rtl/serial_add_sub_if.sv
// serial_add_sub_if
//   Handshake and operand/result bundle for the bit-serial adder/subtractor.
//   master : requester side; drives start, sub, a and b, and observes status and results.
//   slave  : arithmetic unit side; consumes the request and drives busy, done,
//            result, cout and overflow.
//   Signals:
//     start     request, honoured only while the unit is idle
//     sub       0: a+b, 1: a-b (captured together with start)
//     a, b      WIDTH-bit operands (captured together with start)
//     busy      high while operand bits are being processed
//     done      one-cycle pulse when result and flags have just been updated
//     result    WIDTH-bit sum or difference, held until the next completion
//     cout      final carry (subtract: 1 = no borrow)
//     overflow  signed overflow of the completed operation
interface serial_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, cout, overflow
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, cout, overflow
    );
endinterface

// File: rtl/serial_add_sub.sv
// serial_add_sub
//   Bit-serial adder/subtractor. A single full-adder cell plus a carry flip-flop
//   consumes one operand bit per clock, LSB first, so a WIDTH-bit operation takes
//   WIDTH processing cycles followed by one DONE cycle.
//   Subtraction is performed as a + ~b + 1: b is inverted on load and the carry
//   flip-flop is preset to 1.
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous, active-high reset; clears state, outputs and all internal
//           registers, aborting any operation in flight without a done pulse
//     bus   serial_add_sub_if slave modport (start/sub/a/b in; busy/done/result/
//           cout/overflow out)
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input logic            clk,
    input logic            rst,
    serial_add_sub_if.slave bus
);
    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_next_s;

    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] r_sh_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;

    logic [WIDTH-1:0] result_r;
    logic             cout_r;
    logic             overflow_r;
    logic             busy_r;
    logic             done_r;

    logic             sum_s;
    logic             carry_next_s;
    logic             last_s;

    // Majority of three bits: carry-out of a full-adder cell.
    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // Full-adder cell on the current LSBs and detection of the final bit.
    always_comb begin
        sum_s        = a_sh_r[0] ^ b_sh_r[0] ^ carry_r;
        carry_next_s = maj3(a_sh_r[0], b_sh_r[0], carry_r);
        last_s       = (cnt_r == CNT_LAST);
    end

    // Next-state decode of the IDLE -> RUN -> DONE -> IDLE sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Status flags registered from the next state so they mirror the state register exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s == ST_RUN);
            done_r <= (state_next_s == ST_DONE);
        end
    end

    // Operand capture, serial shifting and result/flag update on the final bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_r     <= {WIDTH{1'b0}};
            b_sh_r     <= {WIDTH{1'b0}};
            r_sh_r     <= {WIDTH{1'b0}};
            carry_r    <= 1'b0;
            cnt_r      <= {CW{1'b0}};
            result_r   <= {WIDTH{1'b0}};
            cout_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_sh_r  <= bus.a;
                        b_sh_r  <= bus.sub ? ~bus.b : bus.b;
                        carry_r <= bus.sub;
                        cnt_r   <= {CW{1'b0}};
                    end
                end
                ST_RUN: begin
                    a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
                    r_sh_r  <= {sum_s, r_sh_r[WIDTH-1:1]};
                    carry_r <= carry_next_s;
                    if (last_s) begin
                        // carry_r is the carry into the MSB at this point.
                        result_r   <= {sum_s, r_sh_r[WIDTH-1:1]};
                        cout_r     <= carry_next_s;
                        overflow_r <= carry_r ^ carry_next_s;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    // DONE: outputs hold; nothing to update.
                end
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.result   = result_r;
    assign bus.cout     = cout_r;
    assign bus.overflow = overflow_r;
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub
//   Self-checking bench for serial_add_sub. Drives an 8-bit and a 4-bit instance,
//   checks against an integer-arithmetic reference model, and prints one summary line.
module tb_serial_add_sub;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    serial_add_sub_if #(.WIDTH(8)) bus8 ();
    serial_add_sub_if #(.WIDTH(4)) bus4 ();

    serial_add_sub #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    serial_add_sub #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic void ref_op(input int w, input int av, input int bv, input bit s,
                                   output int r, output bit c, output bit v);
        int m;
        int sa;
        int sb;
        int sr;
        m  = 1 << w;
        sa = (av >= m / 2) ? av - m : av;
        sb = (bv >= m / 2) ? bv - m : bv;
        if (!s) begin
            r  = (av + bv) % m;
            c  = ((av + bv) >= m);
            sr = sa + sb;
        end else begin
            r  = (av - bv + m) % m;
            c  = (av >= bv);
            sr = sa - sb;
        end
        v = (sr > m / 2 - 1) || (sr < -(m / 2));
    endfunction

    // One 8-bit operation; scrambles inputs after the start edge.
    task automatic do_op8(input logic [7:0] av, input logic [7:0] bv, input logic s,
                          output int busy_cycles, output int done_edge, output logic done_after,
                          output logic [7:0] r, output logic c, output logic v);
        bus8.a = av; bus8.b = bv; bus8.sub = s; bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.sub = 1'($urandom);
        busy_cycles = 0;
        done_edge = -1;
        for (int k = 1; k <= 40 && done_edge < 0; k++) begin
            if (bus8.busy === 1'b1) busy_cycles++;
            @(posedge clk); #1;
            if (bus8.done === 1'b1) done_edge = k;
        end
        r = bus8.result; c = bus8.cout; v = bus8.overflow;
        @(posedge clk); #1;
        done_after = bus8.done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus8.busy, bus8.done, bus8.result, bus8.cout, bus8.overflow} !== 12'h000) begin
            $display("FAIL reset8 got busy=%b done=%b res=%h c=%b v=%b want all 0",
                     bus8.busy, bus8.done, bus8.result, bus8.cout, bus8.overflow);
        end else n_pass++;
        n_checks++;
        if ({bus4.busy, bus4.done, bus4.result, bus4.cout, bus4.overflow} !== 8'h00) begin
            $display("FAIL reset4 got busy=%b done=%b res=%h c=%b v=%b want all 0",
                     bus4.busy, bus4.done, bus4.result, bus4.cout, bus4.overflow);
        end else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [7:0] ta [6];
        logic [7:0] tb [6];
        logic       ts [6];
        logic [7:0] tr [6];
        logic       tc [6];
        logic       tv [6];
        int bc, de;
        logic da, c, v;
        logic [7:0] r;
        ta = '{8'h55, 8'hFF, 8'h7F, 8'h05, 8'h80, 8'h00};
        tb = '{8'hAA, 8'h01, 8'h01, 8'h07, 8'h01, 8'h00};
        ts = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1};
        tr = '{8'hFF, 8'h00, 8'h80, 8'hFE, 8'h7F, 8'h00};
        tc = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1};
        tv = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
        for (int i = 0; i < 6; i++) begin
            do_op8(ta[i], tb[i], ts[i], bc, de, da, r, c, v);
            n_checks++;
            if ({r, c, v} !== {tr[i], tc[i], tv[i]}) begin
                $display("FAIL directed%0d got res=%h c=%b v=%b want res=%h c=%b v=%b",
                         i, r, c, v, tr[i], tc[i], tv[i]);
            end else n_pass++;
            n_checks++;
            if (de !== 8 || bc !== 8 || da !== 1'b0) begin
                $display("FAIL timing%0d got done_edge=%0d busy=%0d done_next=%b want 8 8 0",
                         i, de, bc, da);
            end else n_pass++;
        end
    endtask

    task automatic test_random();
        int bc, de, er;
        bit ec, ev;
        logic da, c, v;
        logic [7:0] r, av, bv;
        logic s;
        for (int i = 0; i < 40; i++) begin
            av = 8'($urandom); bv = 8'($urandom); s = 1'($urandom);
            ref_op(8, int'(av), int'(bv), s, er, ec, ev);
            do_op8(av, bv, s, bc, de, da, r, c, v);
            n_checks++;
            if ({r, c, v} !== {8'(er), ec, ev} || de !== 8 || da !== 1'b0) begin
                $display("FAIL random a=%h b=%h sub=%b got res=%h c=%b v=%b de=%0d want res=%h c=%b v=%b de=8",
                         av, bv, s, r, c, v, de, 8'(er), ec, ev);
            end else n_pass++;
        end
    endtask

    task automatic test_ignore_start();
        int dones;
        logic [7:0] got;
        got = 8'h00;
        dones = 0;
        bus8.a = 8'h12; bus8.b = 8'h34; bus8.sub = 1'b0; bus8.start = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 14; k++) begin
            if (k == 3 || k == 8) begin
                bus8.start = 1'b1; bus8.a = 8'hC3; bus8.b = 8'h5A; bus8.sub = 1'b1;
            end else begin
                bus8.start = 1'b0;
            end
            @(posedge clk); #1;
            if (bus8.done === 1'b1) begin
                dones++;
                got = bus8.result;
            end
        end
        bus8.start = 1'b0;
        n_checks++;
        if (dones !== 1) $display("FAIL ignore_done_count got %0d want 1", dones);
        else n_pass++;
        n_checks++;
        if (got !== 8'h46 || bus8.result !== 8'h46) begin
            $display("FAIL ignore_result got %h held %h want 46", got, bus8.result);
        end else n_pass++;
        n_checks++;
        if (bus8.busy !== 1'b0) $display("FAIL ignore_idle got busy=%b want 0", bus8.busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int bc, de, dones;
        logic da, c, v;
        logic [7:0] r;
        bus8.a = 8'h33; bus8.b = 8'h44; bus8.sub = 1'b0; bus8.start = 1'b1;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if ({bus8.busy, bus8.done, bus8.result, bus8.cout, bus8.overflow} !== 12'h000) begin
            $display("FAIL midrst_clear got busy=%b done=%b res=%h c=%b v=%b want all 0",
                     bus8.busy, bus8.done, bus8.result, bus8.cout, bus8.overflow);
        end else n_pass++;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (bus8.done === 1'b1 || bus8.busy === 1'b1) dones++;
        end
        n_checks++;
        if (dones !== 0) $display("FAIL midrst_quiet got %0d active cycles want 0", dones);
        else n_pass++;
        do_op8(8'h10, 8'h20, 1'b0, bc, de, da, r, c, v);
        n_checks++;
        if ({r, c, v, de} !== {8'h30, 1'b0, 1'b0, 32'sd8}) begin
            $display("FAIL midrst_fresh got res=%h c=%b v=%b de=%0d want 30 0 0 8", r, c, v, de);
        end else n_pass++;
    endtask

    task automatic test_exhaustive4();
        int er, de;
        bit ec, ev;
        logic [3:0] r;
        logic c, v, da;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int si = 0; si < 2; si++) begin
                    ref_op(4, ai, bi, si[0], er, ec, ev);
                    bus4.a = 4'(ai); bus4.b = 4'(bi); bus4.sub = si[0]; bus4.start = 1'b1;
                    @(posedge clk); #1;
                    bus4.start = 1'b0; bus4.a = 4'($urandom); bus4.b = 4'($urandom);
                    de = -1;
                    for (int k = 1; k <= 20 && de < 0; k++) begin
                        @(posedge clk); #1;
                        if (bus4.done === 1'b1) de = k;
                    end
                    r = bus4.result; c = bus4.cout; v = bus4.overflow;
                    @(posedge clk); #1;
                    da = bus4.done;
                    n_checks++;
                    if ({r, c, v} !== {4'(er), ec, ev} || de !== 4 || da !== 1'b0) begin
                        $display("FAIL exh4 a=%h b=%h sub=%0d got res=%h c=%b v=%b de=%0d dn=%b want res=%h c=%b v=%b de=4",
                                 ai, bi, si, r, c, v, de, da, 4'(er), ec, ev);
                    end else n_pass++;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus8.start = 1'b0; bus8.sub = 1'b0; bus8.a = 8'h00; bus8.b = 8'h00;
        bus4.start = 1'b0; bus4.sub = 1'b0; bus4.a = 4'h0; bus4.b = 4'h0;
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_mid_run();
        test_exhaustive4();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
